// File: rtl/qbus_dma_seq_pkg.sv
// Shared types and defaults for the central-QBUS DMA / vector-acknowledge sequencer.
package qbus_dma_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GRANT = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_END   = 3'd6,
        ST_VEC   = 3'd7
    } qdma_state_e;

    localparam int TSET_DEF = 2;
    localparam int TOUT_DEF = 255;

endpackage

// File: rtl/qbus_dma_seq_sync.sv
// Two-flop synchronizer, parameterized width; resets to RST_VAL (bus-idle levels).
module qdma_sync #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/qbus_dma_seq.sv
// Central-QBUS sequencer: DMA word transfers, vector acknowledge and bridge strobes.
// Optional RPLY timeout with dma_err is built when QDMA_TIMEOUT_EN is defined.
module qbus_dma_seq
    import qbus_dma_seq_pkg::*;
#(
    parameter int TSET = TSET_DEF,
    parameter int TOUT = TOUT_DEF
) (
    input  logic        PIN_CLK,
    input  logic        PIN_nRESET,
    input  logic        dma_req,
    input  logic        dma_wr,
    output logic        dma_ack,
    output logic        dma_err,
    input  logic        irq_req,
    output logic        irq_ack,
    output logic        PIN_nDMR,
    output logic        PIN_nSACK,
    output logic        PIN_nSYNC,
    output logic        PIN_nDIN,
    output logic        PIN_nDOUT,
    output logic        PIN_nVIRQ,
    output logic        PIN_nIAKO,
    output logic        PIN_nRPLYO,
    input  logic        PIN_nDMGI,
    input  logic        PIN_nRPLY,
    input  logic        PIN_nDINI,
    input  logic        PIN_nIAKI,
    input  logic        PIN_nSYNCI,
    output logic        PIN_nDLA,
    output logic        PIN_nDLD,
    output logic        PIN_nCLD,
    output logic        PIN_nDLV,
    output qdma_state_e dbg_state_o
);

    localparam logic [2:0] TSET_M1 = 3'(TSET - 1);

    logic dmgi_s, rply_s, dini_s, iaki_s, synci_s;

    qdma_sync #(.W(5), .RST_VAL(5'b11111)) u_sync (
        .clk_i  (PIN_CLK),
        .rst_ni (PIN_nRESET),
        .d_i    ({PIN_nDMGI, PIN_nRPLY, PIN_nDINI, PIN_nIAKI, PIN_nSYNCI}),
        .q_o    ({dmgi_s, rply_s, dini_s, iaki_s, synci_s})
    );

    qdma_state_e state_q, state_d, ret_q, ret_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sub_q, sub_d;
    logic        wr_q, wr_d;
    logic        virq_q, virq_d;
    logic        dma_ack_q, dma_ack_d;
    logic        irq_ack_q, irq_ack_d;
    logic        iak;

`ifdef QDMA_TIMEOUT_EN
    localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);
    logic [7:0] tout_q, tout_d;
    logic       err_q, err_d;
    logic       dma_err_q, dma_err_d;
`endif

    // A vector cycle is ours only while our own request is on the bus.
    assign iak = !dini_s && !iaki_s && virq_q;

    always_ff @(posedge PIN_CLK or negedge PIN_nRESET) begin
        if (!PIN_nRESET) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            cnt_q     <= '0;
            sub_q     <= 1'b0;
            wr_q      <= 1'b0;
            virq_q    <= 1'b0;
            dma_ack_q <= 1'b0;
            irq_ack_q <= 1'b0;
`ifdef QDMA_TIMEOUT_EN
            tout_q    <= '0;
            err_q     <= 1'b0;
            dma_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            wr_q      <= wr_d;
            virq_q    <= virq_d;
            dma_ack_q <= dma_ack_d;
            irq_ack_q <= irq_ack_d;
`ifdef QDMA_TIMEOUT_EN
            tout_q    <= tout_d;
            err_q     <= err_d;
            dma_err_q <= dma_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        wr_d      = wr_q;
        virq_d    = irq_req;
        dma_ack_d = 1'b0;
        irq_ack_d = 1'b0;
`ifdef QDMA_TIMEOUT_EN
        tout_d    = '0;
        err_d     = err_q;
        dma_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                sub_d = 1'b0;
                if (iak) begin
                    state_d = ST_VEC;
                    ret_d   = ST_IDLE;
                end else if (dma_req) begin
                    state_d = ST_REQ;
                    wr_d    = dma_wr;
                end
            end
            ST_REQ: begin
                cnt_d = '0;
                sub_d = 1'b0;
                if (iak) begin
                    state_d = ST_VEC;
                    ret_d   = ST_REQ;
                end else if (!dmgi_s && synci_s && rply_s) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_ADDR;
                cnt_d   = '0;
                sub_d   = 1'b0;
`ifdef QDMA_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            // TSET cycles of address setup, then one cycle with SYNC low and nDLA still held.
            ST_ADDR: begin
                if (sub_q) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    sub_d   = 1'b0;
                end else if (cnt_q == TSET_M1) begin
                    sub_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DATA: begin
                if (!wr_q || cnt_q == TSET_M1) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            // The RPLY detect cycle counts as the first deskew cycle.
            ST_WAIT: begin
                if (sub_q || !rply_s) begin
                    if (cnt_q == TSET_M1) begin
                        state_d = ST_END;
                        sub_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        sub_d = 1'b1;
                        cnt_d = cnt_q + 3'd1;
                    end
                end
`ifdef QDMA_TIMEOUT_EN
                else if (tout_q == TOUT_LAST) begin
                    state_d = ST_END;
                    err_d   = 1'b1;
                end else begin
                    tout_d = tout_q + 8'd1;
                end
`endif
            end
            ST_END: begin
                if (rply_s) begin
                    state_d   = ST_IDLE;
                    dma_ack_d = 1'b1;
`ifdef QDMA_TIMEOUT_EN
                    dma_err_d = err_q;
`endif
                end
            end
            ST_VEC: begin
                virq_d = virq_q;
                if (dini_s) begin
                    state_d   = ret_q;
                    virq_d    = 1'b0;
                    irq_ack_d = 1'b1;
                    cnt_d     = '0;
                    sub_d     = 1'b0;
                end else if (!sub_q) begin
                    if (cnt_q == TSET_M1) begin
                        sub_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign PIN_nDMR   = !(state_q == ST_REQ);
    assign PIN_nSACK  = !(state_q inside {ST_GRANT, ST_ADDR, ST_DATA, ST_WAIT, ST_END});
    assign PIN_nSYNC  = !((state_q == ST_ADDR && sub_q) || (state_q inside {ST_DATA, ST_WAIT, ST_END}));
    assign PIN_nDLA   = !(state_q == ST_ADDR);
    assign PIN_nDIN   = !(!wr_q && (state_q inside {ST_DATA, ST_WAIT}));
    assign PIN_nCLD   = !(!wr_q && (state_q inside {ST_DATA, ST_WAIT}));
    assign PIN_nDLD   = !(wr_q && (state_q inside {ST_DATA, ST_WAIT}));
    assign PIN_nDOUT  = !(wr_q && state_q == ST_WAIT);
    assign PIN_nVIRQ  = !virq_q;
    assign PIN_nDLV   = !(state_q == ST_VEC);
    assign PIN_nRPLYO = !(state_q == ST_VEC && sub_q);
    assign PIN_nIAKO  = !(!iaki_s && !virq_q && state_q != ST_VEC);

    assign dma_ack     = dma_ack_q;
    assign irq_ack     = irq_ack_q;
    assign dbg_state_o = state_q;
`ifdef QDMA_TIMEOUT_EN
    assign dma_err = dma_err_q;
`else
    assign dma_err = 1'b0;
`endif

endmodule
